// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch unit: widths, opcode encodings, fetch FSM states.
package isa_pkg;

    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    localparam logic [OPCODE_W-1:0] NOP        = 6'b000000;
    localparam logic [OPCODE_W-1:0] JUMP       = 6'b010101;
    localparam logic [OPCODE_W-1:0] BZ         = 6'b010011;
    localparam logic [OPCODE_W-1:0] PRE_BRANCH = 6'b011111;
    localparam logic [OPCODE_W-1:0] JR         = 6'b100011;
    localparam logic [OPCODE_W-1:0] HLT        = 6'b011100;
    localparam logic [OPCODE_W-1:0] INPUT      = 6'b011101;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_INPUT = 2'd1,
        HALTED     = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC selection for the RUN state.
// Ports: opcode/immediate from the fetched word, zero_latch from the last Pre Branch,
//        reg_target (register operand truncated to an address), pc -> next_pc_c.
module next_pc_select #(
    parameter int unsigned ADDR_W = isa_pkg::ADDR_W
) (
    input  logic [isa_pkg::OPCODE_W-1:0] opcode,
    input  logic [ADDR_W-1:0]            immediate,
    input  logic                         zero_latch,
    input  logic [ADDR_W-1:0]            reg_target,
    input  logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            next_pc_c
);

    logic [ADDR_W-1:0] pc_inc;

    // Sequential successor; wraps naturally at the top of the address space.
    assign pc_inc = pc + ADDR_W'(1);

    always_comb begin
        next_pc_c = pc_inc;
        case (opcode)
            isa_pkg::JUMP: next_pc_c = immediate;
            isa_pkg::BZ:   next_pc_c = zero_latch ? immediate : pc_inc;
            isa_pkg::JR:   next_pc_c = reg_target;
            default:       next_pc_c = pc_inc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the PC to the instruction ROM, registers the fetched
// word for decode, and handles jumps/branches, input stalls and halt.
// Ports: clock, reset_n (async active-low); instruction (ROM data, same cycle),
//        reg_value (register operand), input_valid (external input ready);
//        address (PC), instr_out/instr_valid (to decode), input_request, halted.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W  = isa_pkg::ADDR_W,
    parameter int unsigned INSTR_W = isa_pkg::INSTR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [31:0]        reg_value,
    input  logic               input_valid,
    output logic [ADDR_W-1:0]  address,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               input_request,
    output logic               halted
);

    isa_pkg::fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0]            pc_q, pc_d;
    logic [INSTR_W-1:0]           instr_q, instr_d;
    logic                         valid_q, valid_d;
    logic                         req_q, req_d;
    logic                         halt_q, halt_d;
    logic                         zero_q, zero_d;
    logic [isa_pkg::OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]            next_pc_c;

    assign opcode = instruction[isa_pkg::OPCODE_MSB:isa_pkg::OPCODE_LSB];

    next_pc_select #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_select (
        .opcode     (opcode),
        .immediate  (instruction[ADDR_W-1:0]),
        .zero_latch (zero_q),
        .reg_target (reg_value[ADDR_W-1:0]),
        .pc         (pc_q),
        .next_pc_c  (next_pc_c)
    );

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= isa_pkg::RUN;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
            halt_q  <= halt_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts on it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        req_d   = req_q;
        halt_d  = halt_q;
        zero_d  = zero_q;

        unique case (state_q)
            isa_pkg::RUN: begin
                instr_d = instruction;
                valid_d = 1'b1;
                pc_d    = next_pc_c;
                case (opcode)
                    isa_pkg::PRE_BRANCH: zero_d = (reg_value == 32'd0);
                    isa_pkg::HLT: begin
                        pc_d    = pc_q;
                        halt_d  = 1'b1;
                        state_d = isa_pkg::HALTED;
                    end
                    // Word is captured but only released to decode once input arrives.
                    isa_pkg::INPUT: begin
                        valid_d = 1'b0;
                        req_d   = 1'b1;
                        state_d = isa_pkg::WAIT_INPUT;
                    end
                    default: ;
                endcase
            end
            isa_pkg::WAIT_INPUT: begin
                if (input_valid) begin
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = isa_pkg::RUN;
                end
            end
            isa_pkg::HALTED: ;
            default: state_d = isa_pkg::RUN;
        endcase
    end

    assign address       = pc_q;
    assign instr_out     = instr_q;
    assign instr_valid   = valid_q;
    assign input_request = req_q;
    assign halted        = halt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scoreboard bench for instruction_fetch_unit with a bench-modelled ROM.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] reg_value;
    logic        input_valid;
    logic [9:0]  address;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        input_request;
    logic        halted;

    logic [31:0] rom [1024];

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [9:0]  addr;
        logic [31:0] instr;
        logic        valid;
        logic        req;
        logic        hlt;
    } exp_t;

    exp_t sb[$];

    instruction_fetch_unit #(
        .ADDR_W  (10),
        .INSTR_W (32)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .instruction   (instruction),
        .reg_value     (reg_value),
        .input_valid   (input_valid),
        .address       (address),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .input_request (input_request),
        .halted        (halted)
    );

    assign instruction = rom[address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc(logic [5:0] op, int imm);
        return {op, 26'(imm)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(exp_t e);
        check({e.tag, ".address"},       32'(address),       32'(e.addr));
        check({e.tag, ".instr_out"},     instr_out,          e.instr);
        check({e.tag, ".instr_valid"},   32'(instr_valid),   32'(e.valid));
        check({e.tag, ".input_request"}, 32'(input_request), 32'(e.req));
        check({e.tag, ".halted"},        32'(halted),        32'(e.hlt));
    endtask

    // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
    task automatic step(string tag, logic [31:0] rv, logic iv, logic [9:0] ea,
                        logic [31:0] ei, logic ev, logic er, logic eh);
        exp_t e;
        @(negedge clock);
        reg_value   = rv;
        input_valid = iv;
        sb.push_back('{tag, ea, ei, ev, er, eh});
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_all(e);
        end
    endtask

    initial begin
        exp_t rst_e;
        foreach (rom[i]) rom[i] = 32'h0;
        rom[0]    = enc(isa_pkg::JR, 0);
        rom[1]    = 32'h5400_0051;
        rom[81]   = enc(isa_pkg::JUMP, 12);
        rom[12]   = enc(isa_pkg::PRE_BRANCH, 0);
        rom[13]   = enc(isa_pkg::BZ, 65);
        rom[65]   = enc(isa_pkg::JUMP, 12);
        rom[14]   = enc(isa_pkg::JR, 0);
        rom[111]  = enc(isa_pkg::JUMP, 122);
        rom[122]  = enc(isa_pkg::INPUT, 0);
        rom[123]  = enc(isa_pkg::JUMP, 1023);
        rom[1023] = enc(isa_pkg::NOP, 5);
        rom[133]  = enc(isa_pkg::HLT, 0);

        rst_e = '{"reset", 10'd0, 32'h0, 1'b0, 1'b0, 1'b0};

        reg_value   = 32'd0;
        input_valid = 1'b0;
        reset_n     = 1'b1;
        #1 reset_n  = 1'b0;
        #12;
        check_all(rst_e);
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        check_all(rst_e);

        step("jr0",      32'd1,   1'b0, 10'd1,    rom[0],    1'b1, 1'b0, 1'b0);
        step("jump81",   32'd0,   1'b0, 10'd81,   rom[1],    1'b1, 1'b0, 1'b0);
        step("jump12",   32'd0,   1'b0, 10'd12,   rom[81],   1'b1, 1'b0, 1'b0);
        step("prebr_z",  32'd0,   1'b0, 10'd13,   rom[12],   1'b1, 1'b0, 1'b0);
        step("bz_taken", 32'd7,   1'b0, 10'd65,   rom[13],   1'b1, 1'b0, 1'b0);
        step("jump12b",  32'd0,   1'b0, 10'd12,   rom[65],   1'b1, 1'b0, 1'b0);
        step("prebr_nz", 32'd5,   1'b0, 10'd13,   rom[12],   1'b1, 1'b0, 1'b0);
        step("bz_not",   32'd0,   1'b0, 10'd14,   rom[13],   1'b1, 1'b0, 1'b0);
        step("jr111",    32'd111, 1'b0, 10'd111,  rom[14],   1'b1, 1'b0, 1'b0);
        step("jump122",  32'd0,   1'b0, 10'd122,  rom[111],  1'b1, 1'b0, 1'b0);
        step("input",    32'd0,   1'b0, 10'd123,  rom[122],  1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step("wait",  32'd0,  1'b0, 10'd123,  rom[122],  1'b0, 1'b1, 1'b0);
        step("input_ok", 32'd0,   1'b1, 10'd123,  rom[122],  1'b1, 1'b0, 1'b0);
        step("jump1023", 32'd0,   1'b1, 10'd1023, rom[123],  1'b1, 1'b0, 1'b0);
        step("wrap",     32'd0,   1'b0, 10'd0,    rom[1023], 1'b1, 1'b0, 1'b0);
        step("jr122",    32'd122, 1'b0, 10'd122,  rom[0],    1'b1, 1'b0, 1'b0);
        step("input2",   32'd0,   1'b0, 10'd123,  rom[122],  1'b0, 1'b1, 1'b0);
        step("wait2",    32'd0,   1'b0, 10'd123,  rom[122],  1'b0, 1'b1, 1'b0);

        // Asynchronous reset between edges while waiting on input.
        #2 reset_n = 1'b0;
        #1;
        check_all('{"reset_mid", 10'd0, 32'h0, 1'b0, 1'b0, 1'b0});
        @(posedge clock);
        #1 reset_n = 1'b1;
        #1;
        check_all('{"post_reset", 10'd0, 32'h0, 1'b0, 1'b0, 1'b0});

        step("jr133",    32'd133, 1'b0, 10'd133,  rom[0],    1'b1, 1'b0, 1'b0);
        step("hlt",      32'd0,   1'b0, 10'd133,  rom[133],  1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step("halted", 32'd0, 1'(i % 2), 10'd133, rom[133], 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
